// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its forwarding compare.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle between the 5-stage pipeline datapath (master) and the hazard controller (slave).
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  logic              mem_br_taken;

  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [1:0]        state_o;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic              stall_err;

  modport master (
    output id_rs1, id_rs2, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, mem_br_taken,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
           fwd_a, fwd_b, state_o, stall_cnt, flush_cnt, stall_err
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, mem_br_taken,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
           fwd_a, fwd_b, state_o, stall_cnt, flush_cnt, stall_err
  );

endinterface

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Forwarding compare for one EX-stage ALU operand; EX/MEM result wins over MEM/WB.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_regwrite,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_regwrite,
  output logic [1:0]        o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // A non-zero rd that equals src also guarantees src is not x0.
  assign w_mem_hit = i_mem_regwrite && (i_mem_rd != REG_AW'(REG_X0)) && (i_mem_rd == i_src);
  assign w_wb_hit  = i_wb_regwrite  && (i_wb_rd  != REG_AW'(REG_X0)) && (i_wb_rd  == i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: RAW stall, taken-branch squash, perf counters, stall watchdog.
// Define HAZARD_FWD_EN to enable EX forwarding selects (then only load-use stalls).
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 32,
  parameter int STALL_MAX = 3
) (
  input logic               clk,
  input logic               reset,
  hazard_ctrl_unit_if.slave hz
);

  localparam int WD_W = $clog2(STALL_MAX + 2);

  state_e            r_state;
  state_e            w_state_next;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [WD_W-1:0]   r_run_len;
  logic              r_stall_err;

  logic [REG_AW-1:0] w_dst [3];
  logic [2:0]        w_we;
  logic [2:0]        w_hit;
  logic              w_haz;
  logic              w_flush;
  logic              w_stall;
  logic [1:0]        w_fwd_sel [2];
  logic              w_unused;

  logic              w_pc_write;
  logic              w_ifid_write;
  logic              w_ifid_flush;
  logic              w_idex_flush;
  logic              w_exmem_flush;

  function automatic logic f_match(input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] dst,
                                   input logic              we);
    return we && (src != REG_AW'(REG_X0)) && (src == dst);
  endfunction

  // Writer stages in flight: 0 = EX, 1 = MEM, 2 = WB.
  assign w_dst[0] = hz.ex_rd;
  assign w_dst[1] = hz.mem_rd;
  assign w_dst[2] = hz.wb_rd;
  assign w_we     = {hz.wb_regwrite, hz.mem_regwrite, hz.ex_regwrite};

  for (genvar gi = 0; gi < 3; gi++) begin : g_hit
    assign w_hit[gi] = f_match(hz.id_rs1, w_dst[gi], w_we[gi]) ||
                       (hz.id_use_rs2 && f_match(hz.id_rs2, w_dst[gi], w_we[gi]));
  end

`ifdef HAZARD_FWD_EN
  logic [REG_AW-1:0] w_ex_src [2];

  assign w_ex_src[0] = hz.ex_rs1;
  assign w_ex_src[1] = hz.ex_rs2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_select #(
      .REG_AW (REG_AW)
    ) u_fwd_select (
      .i_src          (w_ex_src[gi]),
      .i_mem_rd       (hz.mem_rd),
      .i_mem_regwrite (hz.mem_regwrite),
      .i_wb_rd        (hz.wb_rd),
      .i_wb_regwrite  (hz.wb_regwrite),
      .o_sel          (w_fwd_sel[gi])
    );
  end

  // Everything except a load in EX is covered by the bypass network.
  assign w_haz    = hz.ex_memread && w_hit[0];
  assign w_unused = ^w_hit[2:1];
`else
  assign w_fwd_sel[0] = FWD_RF;
  assign w_fwd_sel[1] = FWD_RF;
  assign w_haz        = |w_hit;
  assign w_unused     = ^{hz.ex_rs1, hz.ex_rs2, hz.ex_memread};
`endif

  assign w_flush = hz.mem_br_taken;
  assign w_stall = w_haz && !hz.mem_br_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = RUN;
    if (hz.mem_br_taken) begin
      w_state_next = FLUSH;
    end else if (w_haz) begin
      w_state_next = STALL;
    end
  end

  // Pipeline enables follow the inputs directly so a hazard is held off in the same cycle.
  always_comb begin
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    if (!reset) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
    end else if (w_flush) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
    end else if (w_stall) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // Run length parks at STALL_MAX+1 once the limit is crossed; the error stays sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run_len   <= '0;
      r_stall_err <= 1'b0;
    end else if (w_stall) begin
      if (r_run_len >= WD_W'(STALL_MAX)) begin
        r_run_len   <= WD_W'(STALL_MAX + 1);
        r_stall_err <= 1'b1;
      end else begin
        r_run_len <= r_run_len + WD_W'(1);
      end
    end else begin
      r_run_len <= '0;
    end
  end

  assign hz.pc_write    = w_pc_write;
  assign hz.ifid_write  = w_ifid_write;
  assign hz.ifid_flush  = w_ifid_flush;
  assign hz.idex_flush  = w_idex_flush;
  assign hz.exmem_flush = w_exmem_flush;
  assign hz.fwd_a       = reset ? w_fwd_sel[0] : FWD_RF;
  assign hz.fwd_b       = reset ? w_fwd_sel[1] : FWD_RF;
  assign hz.state_o     = r_state;
  assign hz.stall_cnt   = r_stall_cnt;
  assign hz.flush_cnt   = r_flush_cnt;
  assign hz.stall_err   = r_stall_err;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit; expectations adapt to HAZARD_FWD_EN.
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  localparam int REG_AW    = 5;
  localparam int CNT_W     = 32;
  localparam int STALL_MAX = 3;
`ifdef HAZARD_FWD_EN
  localparam int T2_STALLS = 0;
`else
  localparam int T2_STALLS = 3;
`endif

  typedef struct {
    logic [4:0]  ctrl;  // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}
    logic [3:0]  fwd;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fc;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_cyc = 0;
  exp_t sb[$];

  logic [1:0]  m_state = 2'd0;
  logic [31:0] m_sc    = '0;
  logic [31:0] m_fc    = '0;
  int          m_run   = 0;
  logic        m_err   = 1'b0;
  logic [31:0] sc0;
  logic [31:0] fc0;

  hazard_ctrl_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_ctrl_unit #(
    .REG_AW    (REG_AW),
    .CNT_W     (CNT_W),
    .STALL_MAX (STALL_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic mt(input logic [4:0] s, input logic [4:0] d, input logic we);
    return we && (s != 5'd0) && (s == d);
  endfunction

  function automatic logic id_hit(input logic [4:0] d, input logic we);
    return mt(bus.id_rs1, d, we) || (bus.id_use_rs2 && mt(bus.id_rs2, d, we));
  endfunction

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] exp_fwd(input logic [4:0] s);
    if (mt(s, bus.mem_rd, bus.mem_regwrite)) return 2'b10;
    if (mt(s, bus.wb_rd, bus.wb_regwrite)) return 2'b01;
    return 2'b00;
  endfunction
`endif

  task automatic clr_in();
    bus.id_rs1       = '0;
    bus.id_rs2       = '0;
    bus.id_use_rs2   = 1'b0;
    bus.ex_rs1       = '0;
    bus.ex_rs2       = '0;
    bus.ex_rd        = '0;
    bus.ex_regwrite  = 1'b0;
    bus.ex_memread   = 1'b0;
    bus.mem_rd       = '0;
    bus.mem_regwrite = 1'b0;
    bus.wb_rd        = '0;
    bus.wb_regwrite  = 1'b0;
    bus.mem_br_taken = 1'b0;
  endtask

  // Called just after the inputs are set on a falling edge; advances the model to the next rising edge.
  task automatic tick();
    exp_t e;
    exp_t g;
    logic haz;
    logic br;
    logic stall;
    br = bus.mem_br_taken;
`ifdef HAZARD_FWD_EN
    haz = bus.ex_memread && id_hit(bus.ex_rd, bus.ex_regwrite);
`else
    haz = id_hit(bus.ex_rd, bus.ex_regwrite) || id_hit(bus.mem_rd, bus.mem_regwrite) ||
          id_hit(bus.wb_rd, bus.wb_regwrite);
`endif
    stall = haz && !br;
    if (!reset)     e.ctrl = 5'b00111;
    else if (br)    e.ctrl = 5'b11111;
    else if (stall) e.ctrl = 5'b00010;
    else            e.ctrl = 5'b11000;
`ifdef HAZARD_FWD_EN
    e.fwd = reset ? {exp_fwd(bus.ex_rs1), exp_fwd(bus.ex_rs2)} : 4'b0000;
`else
    e.fwd = 4'b0000;
`endif
    e.st  = m_state;
    e.sc  = m_sc;
    e.fc  = m_fc;
    e.err = m_err;
    sb.push_back(e);

    #1;
    g = sb.pop_front();
    chk("ctrl", {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, g.ctrl);
    chk("fwd", {bus.fwd_a, bus.fwd_b}, g.fwd);
    chk("state", bus.state_o, g.st);
    chk("stall_cnt", bus.stall_cnt, g.sc);
    chk("flush_cnt", bus.flush_cnt, g.fc);
    chk("stall_err", bus.stall_err, g.err);
    $display("cyc %0d rst_n=%b br=%b haz=%b ctrl=%b fwd=%b st=%0d sc=%0d fc=%0d err=%b",
             n_cyc, reset, br, haz, bus.pc_write ? {bus.pc_write, bus.ifid_write, bus.ifid_flush,
             bus.idex_flush, bus.exmem_flush} : {bus.pc_write, bus.ifid_write, bus.ifid_flush,
             bus.idex_flush, bus.exmem_flush}, {bus.fwd_a, bus.fwd_b}, bus.state_o,
             bus.stall_cnt, bus.flush_cnt, bus.stall_err);
    n_cyc++;

    if (!reset) begin
      m_state = 2'd0;
      m_sc    = '0;
      m_fc    = '0;
      m_run   = 0;
      m_err   = 1'b0;
    end else begin
      if (br)       m_state = 2'd2;
      else if (haz) m_state = 2'd1;
      else          m_state = 2'd0;
      if (br && (m_fc != '1)) m_fc++;
      if (stall) begin
        if (m_sc != '1) m_sc++;
        m_run++;
        if (m_run > STALL_MAX) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  initial begin
    clr_in();

    // Held in reset: outputs forced even with a taken branch and a hazard present
    @(negedge clk); tick();
    @(negedge clk);
    bus.mem_br_taken = 1'b1; bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1;
    bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
    tick();

    @(negedge clk); reset = 1'b1; clr_in(); tick();

    // 1: load-use on rs1
    @(negedge clk);
    sc0 = m_sc;
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
    tick();
    @(negedge clk); clr_in(); tick();
    chk("t1_stall_cnt", bus.stall_cnt, sc0 + 32'd1);

    // 2: ALU writer of x6 walks EX -> MEM -> WB while ID reads it on rs2
    @(negedge clk); clr_in();
    sc0 = m_sc;
    bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd6; bus.id_rs2 = 5'd6; bus.id_use_rs2 = 1'b1;
    tick();
    @(negedge clk); clr_in();
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd6; bus.id_rs2 = 5'd6; bus.id_use_rs2 = 1'b1;
    tick();
    @(negedge clk); clr_in();
    bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd6; bus.id_rs2 = 5'd6; bus.id_use_rs2 = 1'b1;
    tick();
    @(negedge clk); clr_in(); tick();
    chk("t2_stalls", bus.stall_cnt - sc0, T2_STALLS);
    chk("t2_err", bus.stall_err, 1'b0);

    // 3: taken branch beats a load-use hazard, then a back-to-back taken branch
    @(negedge clk); clr_in();
    sc0 = m_sc; fc0 = m_fc;
    bus.mem_br_taken = 1'b1; bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1;
    bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
    tick();
    @(negedge clk); clr_in(); tick();
    chk("t3_flush_cnt", bus.flush_cnt, fc0 + 32'd1);
    chk("t3_stall_cnt", bus.stall_cnt, sc0);
    @(negedge clk); clr_in(); bus.mem_br_taken = 1'b1; tick();
    @(negedge clk); clr_in(); bus.mem_br_taken = 1'b1; tick();
    @(negedge clk); clr_in(); tick();

    // 4: x0 never hazards; rs2 ignored unless used
    @(negedge clk); clr_in();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.mem_regwrite = 1'b1; bus.wb_regwrite = 1'b1;
    bus.id_use_rs2 = 1'b1;
    tick();
    @(negedge clk); clr_in();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd9; bus.id_rs2 = 5'd9;
    tick();
    @(negedge clk); bus.id_use_rs2 = 1'b1; tick();
    @(negedge clk); clr_in(); tick();

    // 5: forwarding priority EX/MEM over MEM/WB, then MEM/WB alone
    @(negedge clk); clr_in();
    bus.mem_rd = 5'd7; bus.mem_regwrite = 1'b1; bus.wb_rd = 5'd7; bus.wb_regwrite = 1'b1;
    bus.ex_rs1 = 5'd7; bus.ex_rs2 = 5'd7; bus.id_rs1 = 5'd1;
    tick();
    @(negedge clk); bus.mem_regwrite = 1'b0; tick();
    @(negedge clk); bus.wb_rd = 5'd0; bus.ex_rs2 = 5'd0; tick();
    @(negedge clk); clr_in(); bus.wb_rd = 5'd12; bus.wb_regwrite = 1'b1; bus.ex_rs2 = 5'd12; tick();
    @(negedge clk); clr_in(); tick();

    // 6: load-use held four cycles trips the watchdog; async reset mid-stall clears all
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); clr_in();
      bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd3; bus.id_rs1 = 5'd3;
      tick();
    end
    @(negedge clk); clr_in(); tick();
    chk("t6_err_set", bus.stall_err, 1'b1);
    @(negedge clk); clr_in(); tick();
    @(negedge clk); clr_in();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd3; bus.id_rs1 = 5'd3;
    tick();
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_state", bus.state_o, 2'd0);
    chk("t6_rst_stall_cnt", bus.stall_cnt, 32'd0);
    chk("t6_rst_flush_cnt", bus.flush_cnt, 32'd0);
    chk("t6_rst_err", bus.stall_err, 1'b0);
    chk("t6_rst_ctrl", {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush,
                        bus.exmem_flush}, 5'b00111);
    m_state = 2'd0; m_sc = '0; m_fc = '0; m_run = 0; m_err = 1'b0;
    @(negedge clk); tick();
    @(negedge clk); reset = 1'b1; clr_in(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
